// File: rtl/cpu_pkg.sv
// Shared types for the MEM-stage access sequencer: FSM state encoding and default datapath width.
// Also provides the watchdog counter sizing helper.
package cpu_pkg;

    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_e;

    // Width able to hold 0..limit; a disabled watchdog (limit 0) still gets one bit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory request bus: the registered req/we/addr/wdata go out, and the 1-cycle ack returns with rdata.
// The request is held until the ack arrives, or until the watchdog gives up.
interface mem_access_ctrl_if #(
    parameter int DATA_W = cpu_pkg::DEFAULT_DATA_W
);
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_timeout_cnt.sv
// Saturating cycle counter for the access watchdog. expired_o is combinational and rises on the
// limit-th enabled cycle; a limit of 0 never expires. No backpressure.
module mem_timeout_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   cnt_inc;

    assign cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != limit_i)) begin
            cnt_d = cnt_inc[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts the enabled cycles already completed, so the current cycle is cnt_q+1.
    assign expired_o = enable_i && (limit_i != '0) && (cnt_inc >= {1'b0, limit_i});

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: issues one registered dmem request per load/store, and stalls the pipeline until ack or watchdog expiry.
// Latency is 1 cycle to req, then ack+1 to DONE; minimum occupancy is 3 cycles. Backpressure is taken from dmem_ack.
module mem_access_ctrl
    import cpu_pkg::*;
#(
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_read_mem,
    input  logic                mem_write_mem,
    input  logic [DATA_W-1:0]   alu_result_mem,
    input  logic [DATA_W-1:0]   mem_wdata_mem,
    mem_access_ctrl_if.master   dmem,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                stall,
    output logic                wb_bubble,
    output logic                timeout_err
);

    localparam int                CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT_CYCLES);

    mem_state_e        state_q;
    logic              req_q;
    logic              we_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              op_pending;
    logic              wd_expired;

    assign op_pending = mem_read_mem | mem_write_mem;

    mem_timeout_cnt #(.CNT_W(CNT_W)) u_timeout_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (state_q != ACCESS),
        .enable_i  (state_q == ACCESS),
        .limit_i   (LIMIT),
        .expired_o (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (op_pending) begin
                        addr_q  <= alu_result_mem;
                        wdata_q <= mem_wdata_mem;
                        we_q    <= mem_write_mem;
                        req_q   <= 1'b1;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The ack has priority over a watchdog expiry that falls in the same cycle.
                    if (dmem.dmem_ack) begin
                        req_q   <= 1'b0;
                        if (!we_q) rdata_q <= dmem.dmem_rdata;
                        state_q <= DONE;
                    end else if (wd_expired) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        if (!we_q) rdata_q <= '0;
                        state_q <= DONE;
                    end
                end
                // DONE lets EX/MEM advance; the op still visible there has already been served.
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall = rst_n & (((state_q == IDLE) & op_pending) | (state_q == ACCESS));
    assign wb_bubble = stall;

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign mem_rdata       = rdata_q;
    assign timeout_err     = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: unit 0 uses the default watchdog and unit 1 uses a 4-cycle watchdog.
// The expected mem_rdata is queued when each op is issued and popped at DONE.
module tb_mem_access_ctrl;

    localparam int DW   = 32;
    localparam int TO_B = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [1:0]    rd    = '0;
    logic [1:0]    wr    = '0;
    logic [1:0]    ack   = '0;
    logic [DW-1:0] addr [2];
    logic [DW-1:0] wdat [2];
    logic [DW-1:0] rdat [2];
    logic [DW-1:0] mrd  [2];
    logic [1:0]    stl;
    logic [1:0]    bub;
    logic [1:0]    err;

    logic [DW-1:0] hold [2];
    logic [DW-1:0] sb [$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            req_starts0 = 0;
    logic          req_prev0 = 1'b0;

    mem_access_ctrl_if #(.DATA_W(DW)) bus0 ();
    mem_access_ctrl_if #(.DATA_W(DW)) bus1 ();

    assign bus0.dmem_ack   = ack[0];
    assign bus0.dmem_rdata = rdat[0];
    assign bus1.dmem_ack   = ack[1];
    assign bus1.dmem_rdata = rdat[1];

    mem_access_ctrl #(.DATA_W(DW)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .mem_read_mem(rd[0]), .mem_write_mem(wr[0]),
        .alu_result_mem(addr[0]), .mem_wdata_mem(wdat[0]),
        .dmem(bus0),
        .mem_rdata(mrd[0]), .stall(stl[0]), .wb_bubble(bub[0]), .timeout_err(err[0])
    );

    mem_access_ctrl #(.DATA_W(DW), .TIMEOUT_CYCLES(TO_B)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .mem_read_mem(rd[1]), .mem_write_mem(wr[1]),
        .alu_result_mem(addr[1]), .mem_wdata_mem(wdat[1]),
        .dmem(bus1),
        .mem_rdata(mrd[1]), .stall(stl[1]), .wb_bubble(bub[1]), .timeout_err(err[1])
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus0.dmem_req && !req_prev0) req_starts0++;
        req_prev0 = bus0.dmem_req;
    end

    function automatic logic f_req(input int u);
        return (u == 0) ? bus0.dmem_req : bus1.dmem_req;
    endfunction
    function automatic logic f_we(input int u);
        return (u == 0) ? bus0.dmem_we : bus1.dmem_we;
    endfunction
    function automatic logic [DW-1:0] f_addr(input int u);
        return (u == 0) ? bus0.dmem_addr : bus1.dmem_addr;
    endfunction
    function automatic logic [DW-1:0] f_wdata(input int u);
        return (u == 0) ? bus0.dmem_wdata : bus1.dmem_wdata;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Entered at posedge+1 with the unit idle; returns at posedge+1 just after the DONE cycle.
    task automatic do_op(input int u, input bit is_wr, input bit both, input logic [DW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] rdv, input int delay,
                         input int exp_reqc, input bit exp_to, input bit exp_err, input string tag);
        int reqc;
        int stallc;
        bit done;
        bit stable;
        rd[u]   = !is_wr || both;
        wr[u]   = is_wr;
        addr[u] = a;
        wdat[u] = wd;
        if (!is_wr) hold[u] = exp_to ? '0 : rdv;
        sb.push_back(hold[u]);
        @(negedge clk);
        check({tag, ":stall_T"}, stl[u], 1);
        check({tag, ":req_T"}, f_req(u), 0);
        stallc = 1; reqc = 0; done = 1'b0; stable = 1'b1;
        for (int c = 0; c < 64 && !done; c++) begin
            @(posedge clk); #1;
            ack[u] = 1'b0;
            if (f_req(u)) begin
                reqc++;
                ack[u]  = (delay >= 0) && (reqc == delay + 1);
                rdat[u] = ack[u] ? rdv : (32'hBAD0_0000 | 32'(reqc));
                @(negedge clk);
                if (stl[u] === 1'b1) stallc++;
                if (f_we(u) !== is_wr || f_addr(u) !== a || f_wdata(u) !== wd) stable = 1'b0;
            end else begin
                done = 1'b1;
                @(negedge clk);
            end
        end
        check({tag, ":done_reached"}, done, 1);
        check({tag, ":req_cycles"}, reqc, exp_reqc);
        check({tag, ":stall_cycles"}, stallc, exp_reqc + 1);
        check({tag, ":fields_stable"}, stable, 1);
        check({tag, ":stall_done"}, stl[u], 0);
        check({tag, ":bubble_eq_stall"}, bub[u], stl[u]);
        check({tag, ":rdata"}, mrd[u], sb.pop_front());
        check({tag, ":timeout_err"}, err[u], exp_err);
        @(posedge clk); #1;
        rd[u] = 1'b0; wr[u] = 1'b0; ack[u] = 1'b0;
    endtask

    initial begin
        int s;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; wdat[i] = '0; rdat[i] = '0; hold[i] = '0;
        end
        // Reset with an op already pending: stall must stay low.
        #2 rst_n = 1'b0;
        rd[0] = 1'b1;
        #1;
        check("rst:req", bus0.dmem_req, 0);
        check("rst:we", bus0.dmem_we, 0);
        check("rst:addr", bus0.dmem_addr, 0);
        check("rst:wdata", bus0.dmem_wdata, 0);
        check("rst:rdata", mrd[0], 0);
        check("rst:err", err[0], 0);
        check("rst:stall_forced", stl[0], 0);
        check("rst:bubble", bub[0], 0);
        repeat (2) @(posedge clk);
        #1 rd[0] = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(0, 0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1, 0, 0, "load_k0");
        do_op(0, 1, 0, 32'h20, 32'h12345678, 32'h0, 5, 6, 0, 0, "store_k5");
        do_op(0, 1, 1, 32'h24, 32'hA5A5_5A5A, 32'h0, 1, 2, 0, 0, "store_and_read");

        s = req_starts0;
        do_op(0, 0, 0, 32'h4, 32'h0, 32'h1111_0004, 2, 3, 0, 0, "b2b_a");
        do_op(0, 0, 0, 32'h8, 32'h0, 32'h2222_0008, 2, 3, 0, 0, "b2b_b");
        check("b2b:req_count", req_starts0 - s, 2);

        do_op(1, 0, 0, 32'h30, 32'h0, 32'hC0FFEE00, TO_B - 1, TO_B, 0, 0, "ack_at_expiry");

        ack[1] = 1'b1; rdat[1] = 32'hFFFF_FFFF;
        @(negedge clk);
        check("spur:req", bus1.dmem_req, 0);
        check("spur:stall", stl[1], 0);
        @(posedge clk); #1 ack[1] = 1'b0;
        @(negedge clk);
        check("spur:req_after", bus1.dmem_req, 0);
        check("spur:rdata", mrd[1], hold[1]);
        check("spur:err", err[1], 0);
        @(posedge clk); #1;
        do_op(1, 0, 0, 32'h34, 32'h0, 32'h0BADF00D, 0, 1, 0, 0, "after_spur");

        do_op(1, 0, 0, 32'h38, 32'h0, 32'h9999_9999, -1, TO_B, 1, 1, "timeout");
        do_op(1, 0, 0, 32'h3C, 32'h0, 32'h600D_0001, 1, 2, 0, 1, "sticky_err");

        rd[0] = 1'b1; addr[0] = 32'h40;
        @(negedge clk);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rstmid:req_before", bus0.dmem_req, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid:req", bus0.dmem_req, 0);
        check("rstmid:addr", bus0.dmem_addr, 0);
        check("rstmid:stall", stl[0], 0);
        check("rstmid:rdata", mrd[0], 0);
        check("rstmid:err1_cleared", err[1], 0);
        hold[0] = '0; hold[1] = '0;
        rd[0] = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 ack[0] = 1'b1; rdat[0] = 32'h5555_AAAA;
        @(negedge clk);
        check("late_ack:req", bus0.dmem_req, 0);
        check("late_ack:stall", stl[0], 0);
        @(posedge clk); #1 ack[0] = 1'b0;
        @(negedge clk);
        check("late_ack:rdata", mrd[0], 0);
        @(posedge clk); #1;
        do_op(0, 0, 0, 32'h44, 32'h0, 32'h7777_8888, 0, 1, 0, 0, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "bench time limit exceeded");
    end

endmodule
